// File: rtl/ksa_mp_seq.sv
// ksa_mp_seq: multi-precision sequential adder.
//
// Operands of NW words of W bits each are captured on an input valid/ready
// handshake. They are then summed one word per cycle, least significant word
// first, through a single combinational W-bit Kogge-Stone adder stage. The
// carry between words lives in a register, so A/B never reach the outputs
// combinationally. The finished sum and top carry are held until the output
// valid/ready handshake.
//
// Optional feature: define KSA_MP_SUB_EN to add the Sub input. With Sub=1,
// B is inverted word by word and the initial carry becomes Cin ^ Sub. This
// gives A - B - Cin, with Cin acting as borrow-in and Cout=1 meaning no
// borrow out.
//
// Ports:
//   clk        clock, all state changes on the rising edge
//   rst        synchronous active-high reset
//   in_valid   operand set A/B/Cin (and Sub) is valid
//   in_ready   block can accept a new operand set (high only in IDLE)
//   A, B       W*NW-bit operands, captured on the input handshake
//   Cin        carry in to word 0, captured on the input handshake
//   Sub        (KSA_MP_SUB_EN only) subtract select, captured on handshake
//   out_valid  S and Cout hold a completed result
//   out_ready  downstream consumes the result
//   S          registered W*NW-bit sum
//   Cout       registered carry out of the top word
module ksa_mp_seq #(
    parameter int unsigned W  = 16,
    parameter int unsigned NW = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [W*NW-1:0] A,
    input  logic [W*NW-1:0] B,
    input  logic            Cin,
`ifdef KSA_MP_SUB_EN
    input  logic            Sub,
`endif
    output logic            out_valid,
    input  logic            out_ready,
    output logic [W*NW-1:0] S,
    output logic            Cout
);

    localparam int unsigned IW   = (NW > 1) ? $clog2(NW) : 1;
    localparam int unsigned Lvls = $clog2(W);
    localparam logic [IW-1:0] LastIdx = IW'(NW - 1);

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StDone
    } state_e;

    // W-bit Kogge-Stone adder stage. It is purely combinational and returns
    // {carry_out, sum}.
    function automatic logic [W:0] ks_add(input logic [W-1:0] a,
                                          input logic [W-1:0] b,
                                          input logic         ci);
        logic [W-1:0] x;
        logic [W-1:0] g;
        logic [W-1:0] p;
        logic [W-1:0] g_n;
        logic [W-1:0] p_n;
        logic [W:0]   c;
        x = a ^ b;
        g = a & b;
        p = x;
        // Parallel prefix: after level l, g[i]/p[i] span bits i down to
        // max(0, i - 2^(l+1) + 1).
        for (int l = 0; l < int'(Lvls); l++) begin
            g_n = g;
            p_n = p;
            for (int i = (1 << l); i < int'(W); i++) begin
                g_n[i] = g[i] | (p[i] & g[i - (1 << l)]);
                p_n[i] = p[i] & p[i - (1 << l)];
            end
            g = g_n;
            p = p_n;
        end
        // Group terms now cover bits [i:0]. Fold the carry in last.
        c[0] = ci;
        for (int i = 0; i < int'(W); i++) begin
            c[i+1] = g[i] | (p[i] & ci);
        end
        return {c[W], x ^ c[W-1:0]};
    endfunction

    state_e            state_q;
    logic [W*NW-1:0]   a_q;
    logic [W*NW-1:0]   b_q;
    logic [IW-1:0]     idx_q;
    logic              carry_q;
    logic [W*NW-1:0]   s_q;
    logic              cout_q;
    logic              in_ready_q;
    logic              out_valid_q;
`ifdef KSA_MP_SUB_EN
    logic              sub_q;
`endif

    logic [W-1:0]      a_word;
    logic [W-1:0]      b_word;
    logic              carry_init;
    logic [W:0]        stage_res;

    // Word-k operand select and adder stage for the current RUN cycle.
    always_comb begin
        a_word = a_q[idx_q*W +: W];
`ifdef KSA_MP_SUB_EN
        b_word     = b_q[idx_q*W +: W] ^ {W{sub_q}};
        carry_init = Cin ^ Sub;
`else
        b_word     = b_q[idx_q*W +: W];
        carry_init = Cin;
`endif
        stage_res = ks_add(a_word, b_word, carry_q);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StIdle;
            a_q         <= '0;
            b_q         <= '0;
            idx_q       <= '0;
            carry_q     <= 1'b0;
            s_q         <= '0;
            cout_q      <= 1'b0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
`ifdef KSA_MP_SUB_EN
            sub_q       <= 1'b0;
`endif
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (in_valid) begin
                        a_q        <= A;
                        b_q        <= B;
                        idx_q      <= '0;
                        carry_q    <= carry_init;
`ifdef KSA_MP_SUB_EN
                        sub_q      <= Sub;
`endif
                        in_ready_q <= 1'b0;
                        state_q    <= StRun;
                    end
                end
                StRun: begin
                    s_q[idx_q*W +: W] <= stage_res[W-1:0];
                    carry_q           <= stage_res[W];
                    if (idx_q == LastIdx) begin
                        cout_q      <= stage_res[W];
                        out_valid_q <= 1'b1;
                        state_q     <= StDone;
                    end else begin
                        idx_q <= idx_q + 1'b1;
                    end
                end
                StDone: begin
                    // No bypass: in_ready returns one cycle after the
                    // output handshake.
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        state_q     <= StIdle;
                    end
                end
                default: begin
                    out_valid_q <= 1'b0;
                    in_ready_q  <= 1'b1;
                    state_q     <= StIdle;
                end
            endcase
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign S         = s_q;
    assign Cout      = cout_q;

endmodule

// File: tb/tb_ksa_mp_seq.sv
module tb_ksa_mp_seq;

    localparam int W  = 16;
    localparam int NW = 4;
    localparam int TW = W * NW;

    logic          clk;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    logic [TW-1:0] a;
    logic [TW-1:0] b;
    logic          cin;
`ifdef KSA_MP_SUB_EN
    logic          sub;
`endif
    logic          out_valid;
    logic          out_ready;
    logic [TW-1:0] s;
    logic          cout;

    int            errors;
    int            checks;
    integer        seed;

    ksa_mp_seq #(
        .W  (W),
        .NW (NW)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .A         (a),
        .B         (b),
        .Cin       (cin),
`ifdef KSA_MP_SUB_EN
        .Sub       (sub),
`endif
        .out_valid (out_valid),
        .out_ready (out_ready),
        .S         (s),
        .Cout      (cout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [TW:0] got, input logic [TW:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [TW:0] model_add(input logic [TW-1:0] x, input logic [TW-1:0] y,
                                              input logic c);
        return {1'b0, x} + {1'b0, y} + {{TW{1'b0}}, c};
    endfunction

    // Called at #1 after a rising edge; returns at #1 after the accept edge.
    task automatic start_op(input logic [TW-1:0] x, input logic [TW-1:0] y, input logic c,
                            input logic sb);
        int n;
        n = 0;
        while (in_ready !== 1'b1 && n < 64) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (n >= 64) check("start_timeout", 65'(n), 65'(0));
        in_valid = 1'b1;
        a        = x;
        b        = y;
        cin      = c;
`ifdef KSA_MP_SUB_EN
        sub      = sb;
`else
        if (sb) $display("note: Sub ignored in this build");
`endif
        @(posedge clk);
        #1;
        in_valid = 1'b0;
`ifdef KSA_MP_SUB_EN
        sub      = 1'b0;
`endif
    endtask

    task automatic wait_out(output int lat);
        lat = 0;
        while (out_valid !== 1'b1 && lat < 64) begin
            @(posedge clk);
            #1;
            lat++;
        end
    endtask

    task automatic release_out();
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
    endtask

    initial begin
        int            lat;
        logic [TW:0]   exp;
        logic [TW:0]   q[$];
        int            sent;
        int            recv;
        bit            acc;
        bit            seen;

        errors    = 0;
        checks    = 0;
        seed      = 32'd20240611;
        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        a         = '0;
        b         = '0;
        cin       = 1'b0;
`ifdef KSA_MP_SUB_EN
        sub       = 1'b0;
`endif
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;

        // Reset state
        check("rst_in_ready", 65'(in_ready), 65'(1));
        check("rst_out_valid", 65'(out_valid), 65'(0));
        check("rst_sum", {cout, s}, 65'(0));

        // 1: all-ones + carry in wraps to zero, latency NW
        start_op(64'hFFFF_FFFF_FFFF_FFFF, 64'h0, 1'b1, 1'b0);
        check("t1_valid_early", 65'(out_valid), 65'(0));
        wait_out(lat);
        check("t1_latency", 65'(lat), 65'(4));
        check("t1_sum", {cout, s}, {1'b1, 64'h0});
        release_out();
        check("t1_in_ready_after", 65'(in_ready), 65'(1));
        check("t1_out_valid_after", 65'(out_valid), 65'(0));

        // 2: inter-word carry and top-word overflow
        start_op(64'h0000_0000_0000_FFFF, 64'h1, 1'b0, 1'b0);
        wait_out(lat);
        check("t2a_latency", 65'(lat), 65'(4));
        check("t2a_sum", {cout, s}, {1'b0, 64'h0000_0000_0001_0000});
        release_out();
        start_op(64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 1'b0, 1'b0);
        wait_out(lat);
        check("t2b_sum", {cout, s}, {1'b1, 64'h0});
        release_out();

        // 3: backpressure in DONE, stray in_valid ignored
        exp = model_add(64'h1234_5678_9ABC_DEF0, 64'h1111_1111_1111_1111, 1'b0);
        start_op(64'h1234_5678_9ABC_DEF0, 64'h1111_1111_1111_1111, 1'b0, 1'b0);
        wait_out(lat);
        check("t3_latency", 65'(lat), 65'(4));
        for (int i = 0; i < 10; i++) begin
            if (i == 3) begin
                in_valid = 1'b1;
                a        = 64'hDEAD_BEEF_0000_0001;
                b        = 64'h0F0F_0F0F_0F0F_0F0F;
                cin      = 1'b1;
            end else begin
                in_valid = 1'b0;
            end
            @(posedge clk);
            #1;
            check("t3_hold_sum", {cout, s}, exp);
            check("t3_hold_valid", 65'(out_valid), 65'(1));
            check("t3_hold_in_ready", 65'(in_ready), 65'(0));
        end
        in_valid = 1'b0;
        release_out();
        check("t3_in_ready_after", 65'(in_ready), 65'(1));
        check("t3_out_valid_after", 65'(out_valid), 65'(0));
        seen = 1'b0;
        repeat (8) begin
            @(posedge clk);
            #1;
            if (out_valid === 1'b1) seen = 1'b1;
        end
        check("t3_no_stray_op", 65'(seen), 65'(0));

        // 4: reset in RUN at word 2 abandons the operation
        start_op(64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        check("t4_in_ready", 65'(in_ready), 65'(1));
        check("t4_out_valid", 65'(out_valid), 65'(0));
        check("t4_sum_cleared", {cout, s}, 65'(0));
        seen = 1'b0;
        repeat (6) begin
            @(posedge clk);
            #1;
            if (out_valid === 1'b1) seen = 1'b1;
        end
        check("t4_no_partial", 65'(seen), 65'(0));
        start_op(64'd3, 64'd4, 1'b0, 1'b0);
        wait_out(lat);
        check("t4_latency", 65'(lat), 65'(4));
        check("t4_sum", {cout, s}, 65'(7));
        release_out();

        // 5: random back-to-back traffic with output stalls
        sent = 0;
        recv = 0;
        for (int cyc = 0; cyc < 20000 && recv < 200; cyc++) begin
            @(negedge clk);
            acc = 1'b0;
            if (in_valid && in_ready) begin
                q.push_back(model_add(a, b, cin));
                sent++;
                acc = 1'b1;
            end
            if (out_valid && out_ready) begin
                if (q.size() == 0) check("rnd_unexpected_out", 65'(1), 65'(0));
                else check("rnd_sum", {cout, s}, q.pop_front());
                recv++;
            end
            @(posedge clk);
            #1;
            if (acc || !in_valid) begin
                if (sent < 200 && ($random(seed) & 3) != 0) begin
                    in_valid = 1'b1;
                    a        = {$random(seed), $random(seed)};
                    b        = {$random(seed), $random(seed)};
                    if (($random(seed) & 7) == 0) b = ~a;
                    cin      = 1'($random(seed));
                end else begin
                    in_valid = 1'b0;
                end
            end
            out_ready = (($random(seed) & 3) != 0);
        end
        in_valid  = 1'b0;
        out_ready = 1'b0;
        check("rnd_out_count", 65'(recv), 65'(200));
        check("rnd_in_out_match", 65'(recv), 65'(sent));

`ifdef KSA_MP_SUB_EN
        // 6: subtraction with borrow
        start_op(64'd5, 64'd7, 1'b0, 1'b1);
        wait_out(lat);
        check("t6a_sub", {cout, s}, {1'b0, 64'hFFFF_FFFF_FFFF_FFFE});
        release_out();
        start_op(64'd7, 64'd5, 1'b1, 1'b1);
        wait_out(lat);
        check("t6b_sub", {cout, s}, {1'b1, 64'h1});
        release_out();
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
